// File: rtl/sha3_miner_pkg.sv
// Shared register map and bit-field positions for the SHA3 miner host CSR block.
package sha3_miner_pkg;

  // Word addresses on the Avalon-MM slave
  localparam logic [4:0] ADDR_HDR0     = 5'h00;
  localparam logic [4:0] ADDR_DIFF0    = 5'h08;
  localparam logic [4:0] ADDR_NONCE_LO = 5'h10;
  localparam logic [4:0] ADDR_NONCE_HI = 5'h11;
  localparam logic [4:0] ADDR_CTL      = 5'h12;
  localparam logic [4:0] ADDR_STATUS   = 5'h13;
  localparam logic [4:0] ADDR_SOL_LO   = 5'h14;
  localparam logic [4:0] ADDR_SOL_HI   = 5'h15;
  localparam logic [4:0] ADDR_IRQ_CTL  = 5'h16;
  localparam logic [4:0] ADDR_RUNCNT   = 5'h17;

  // Miner control word fields (LSB positions)
  localparam int unsigned CTL_RUN  = 0;
  localparam int unsigned CTL_TEST = 1;
  localparam int unsigned CTL_HALT = 2;
  localparam int unsigned CTL_PADL = 3;
  localparam int unsigned CTL_PADF = 11;

  // Miner status input bits
  localparam int unsigned STS_IRQ    = 0;
  localparam int unsigned STS_RUN    = 1;
  localparam int unsigned STS_TEST   = 2;
  localparam int unsigned STS_STAGES = 3;

  // Status register (0x13) extra bits above the raw miner status
  localparam int unsigned SREG_PENDING   = 8;
  localparam int unsigned SREG_IRQ_EN    = 9;
  localparam int unsigned SREG_WP_ERR    = 10;
  localparam int unsigned SREG_MINER_IRQ = 11;

  // irq_ctl register (0x16) bits
  localparam int unsigned IRQC_PENDING = 0;
  localparam int unsigned IRQC_EN      = 1;
  localparam int unsigned IRQC_WP_ERR  = 2;

  // Job registers are the ones frozen while the miner runs
  function automatic logic is_job_addr(input logic [4:0] addr);
    return addr <= ADDR_NONCE_HI;
  endfunction

endpackage

// File: rtl/sha3_miner_irq_ctrl.sv
// Miner IRQ edge detection, sticky pending flag, enable and registered host irq.
module sha3_miner_irq_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic miner_irq,
  input  logic clr_pending,
  input  logic en_we,
  input  logic en_wd,
  output logic rise,
  output logic pending,
  output logic irq_en,
  output logic irq_out
);

  logic miner_irq_d;

  assign rise = miner_irq & ~miner_irq_d;

  // Pending is set by a miner rise; a simultaneous host clear loses to the set
  always_ff @(posedge clk) begin
    if (rst) begin
      miner_irq_d <= 1'b0;
      pending     <= 1'b0;
      irq_en      <= 1'b0;
      irq_out     <= 1'b0;
    end else begin
      miner_irq_d <= miner_irq;
      if (rise)
        pending <= 1'b1;
      else if (clr_pending)
        pending <= 1'b0;
      if (en_we)
        irq_en <= en_wd;
      irq_out <= pending & irq_en;
    end
  end

endmodule

// File: rtl/sha3_miner_csr.sv
// Avalon-MM register file fronting the SHA3-256 miner: job registers,
// control, solution capture, sticky interrupt and run-cycle counter.
module sha3_miner_csr
  import sha3_miner_pkg::*;
#(
  parameter int unsigned CTL_W = 19,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             irq_out,
  output logic [255:0]     header,
  output logic [255:0]     difficulty,
  output logic [63:0]      start_nonce,
  output logic [CTL_W-1:0] control,
  input  logic [63:0]      solution,
  input  logic [6:0]       status,
  input  logic             miner_irq
);

  logic [63:0]      sol_cap;
  logic [31:0]      sol_hi_shadow;
  logic             wp_err;
  logic [CNT_W-1:0] run_cnt;
  logic             rise;
  logic             pending;
  logic             irq_en;
  logic [31:0]      rd_mux;

  logic wr_irq_ctl;
  logic wr_runcnt;

  assign wr_irq_ctl = avs_write && (avs_address == ADDR_IRQ_CTL);
  assign wr_runcnt  = avs_write && (avs_address == ADDR_RUNCNT);

  sha3_miner_irq_ctrl u_irq_ctrl (
    .clk         (clk),
    .rst         (rst),
    .miner_irq   (miner_irq),
    .clr_pending (wr_irq_ctl && avs_writedata[IRQC_PENDING]),
    .en_we       (wr_irq_ctl),
    .en_wd       (avs_writedata[IRQC_EN]),
    .rise        (rise),
    .pending     (pending),
    .irq_en      (irq_en),
    .irq_out     (irq_out)
  );

  // Job/control register writes; job writes while running are dropped and flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      header      <= '0;
      difficulty  <= '0;
      start_nonce <= '0;
      control     <= '0;
      wp_err      <= 1'b0;
    end else if (avs_write) begin
      if (is_job_addr(avs_address)) begin
        if (control[CTL_RUN])
          wp_err <= 1'b1;
        else if (avs_address[4])
          start_nonce[{avs_address[0], 5'b0} +: 32] <= avs_writedata;
        else if (avs_address[3])
          difficulty[{avs_address[2:0], 5'b0} +: 32] <= avs_writedata;
        else
          header[{avs_address[2:0], 5'b0} +: 32] <= avs_writedata;
      end else if (avs_address == ADDR_CTL) begin
        control <= avs_writedata[CTL_W-1:0];
      end else if (avs_address == ADDR_IRQ_CTL && avs_writedata[IRQC_WP_ERR]) begin
        wp_err <= 1'b0;
      end
    end
  end

  // Solution capture on miner rise; reading the low word latches the high word
  always_ff @(posedge clk) begin
    if (rst) begin
      sol_cap       <= '0;
      sol_hi_shadow <= '0;
    end else begin
      if (rise)
        sol_cap <= solution;
      if (avs_read && avs_address == ADDR_SOL_LO)
        sol_hi_shadow <= sol_cap[63:32];
    end
  end

  // Run-cycle counter: host write clears and beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst)
      run_cnt <= '0;
    else if (wr_runcnt)
      run_cnt <= '0;
    else if (status[STS_RUN] && !miner_irq)
      run_cnt <= run_cnt + 1'b1;
  end

  // Read mux over pre-write register state
  always_comb begin
    rd_mux = '0;
    if (avs_address < ADDR_DIFF0) begin
      rd_mux = header[{avs_address[2:0], 5'b0} +: 32];
    end else if (avs_address < ADDR_NONCE_LO) begin
      rd_mux = difficulty[{avs_address[2:0], 5'b0} +: 32];
    end else begin
      case (avs_address)
        ADDR_NONCE_LO: rd_mux = start_nonce[31:0];
        ADDR_NONCE_HI: rd_mux = start_nonce[63:32];
        ADDR_CTL:      rd_mux[CTL_W-1:0] = control;
        ADDR_STATUS:   rd_mux = {20'b0, miner_irq, wp_err, irq_en, pending, 1'b0, status};
        ADDR_SOL_LO:   rd_mux = sol_cap[31:0];
        ADDR_SOL_HI:   rd_mux = sol_hi_shadow;
        ADDR_IRQ_CTL:  rd_mux = {29'b0, wp_err, irq_en, pending};
        ADDR_RUNCNT:   rd_mux[CNT_W-1:0] = run_cnt;
        default:       rd_mux = '0;
      endcase
    end
  end

  // Fixed one-cycle read response
  always_ff @(posedge clk) begin
    if (rst) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      avs_readdata      <= avs_read ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_sha3_miner_csr.sv
// Self-checking bench for sha3_miner_csr: directed plan plus random traffic
// checked against a register-map level model.
module tb_sha3_miner_csr;

  localparam int unsigned CTL_W = 19;
  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rst;
  logic [4:0]       avs_address;
  logic             avs_read;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic [31:0]      avs_readdata;
  logic             avs_readdatavalid;
  logic             irq_out;
  logic [255:0]     header;
  logic [255:0]     difficulty;
  logic [63:0]      start_nonce;
  logic [CTL_W-1:0] control;
  logic [63:0]      solution;
  logic [6:0]       status;
  logic             miner_irq;

  sha3_miner_csr #(.CTL_W(CTL_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq_out           (irq_out),
    .header            (header),
    .difficulty        (difficulty),
    .start_nonce       (start_nonce),
    .control           (control),
    .solution          (solution),
    .status            (status),
    .miner_irq         (miner_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain arrays of register words
  logic [31:0]      m_hdr   [8];
  logic [31:0]      m_diff  [8];
  logic [31:0]      m_nonce [2];
  logic [CTL_W-1:0] m_ctl;
  logic             m_pend, m_en, m_wperr, m_irqd, m_irqout;
  logic [63:0]      m_sol;
  logic [31:0]      m_shadow;
  logic [31:0]      m_cnt;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_hdr[i]  = '0;
      m_diff[i] = '0;
    end
    m_nonce[0] = '0;
    m_nonce[1] = '0;
    m_ctl = '0; m_pend = 0; m_en = 0; m_wperr = 0; m_irqd = 0; m_irqout = 0;
    m_sol = '0; m_shadow = '0; m_cnt = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    if (a < 8)       r = m_hdr[a[2:0]];
    else if (a < 16) r = m_diff[a[2:0]];
    else begin
      case (a)
        5'h10: r = m_nonce[0];
        5'h11: r = m_nonce[1];
        5'h12: r[CTL_W-1:0] = m_ctl;
        5'h13: r = {20'b0, miner_irq, m_wperr, m_en, m_pend, 1'b0, status};
        5'h14: r = m_sol[31:0];
        5'h15: r = m_shadow;
        5'h16: r = {29'b0, m_wperr, m_en, m_pend};
        5'h17: r = m_cnt;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic chk_ports(input string tag);
    logic [255:0] h, d;
    for (int i = 0; i < 8; i++) begin
      h[32*i +: 32] = m_hdr[i];
      d[32*i +: 32] = m_diff[i];
    end
    chk({tag, "_header"}, header, h);
    chk({tag, "_difficulty"}, difficulty, d);
    chk({tag, "_nonce"}, start_nonce, {m_nonce[1], m_nonce[0]});
    chk({tag, "_control"}, control, m_ctl);
  endtask

  // One bus cycle: drive, clock, advance the model, check response
  task automatic step(input bit rd, input bit wr, input logic [4:0] a, input logic [31:0] wd,
                      output logic [31:0] got);
    logic [31:0] exp_rd;
    logic        rise, nxt_irq;
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
    exp_rd = m_read(a);
    @(posedge clk);
    rise    = miner_irq && !m_irqd;
    nxt_irq = m_pend && m_en;
    if (wr) begin
      if (a <= 5'h11) begin
        if (m_ctl[0])    m_wperr = 1'b1;
        else if (a < 8)  m_hdr[a[2:0]] = wd;
        else if (a < 16) m_diff[a[2:0]] = wd;
        else             m_nonce[a[0]] = wd;
      end else if (a == 5'h12) begin
        m_ctl = wd[CTL_W-1:0];
      end else if (a == 5'h16) begin
        if (wd[0]) m_pend = 1'b0;
        m_en = wd[1];
        if (wd[2]) m_wperr = 1'b0;
      end
    end
    if (wr && a == 5'h17)               m_cnt = '0;
    else if (status[1] && !miner_irq)   m_cnt = m_cnt + 1;
    if (rd && a == 5'h14)               m_shadow = m_sol[63:32];
    if (rise) begin
      m_pend = 1'b1;
      m_sol  = solution;
    end
    m_irqd   = miner_irq;
    m_irqout = nxt_irq;
    #1;
    chk("readdatavalid", avs_readdatavalid, rd);
    if (rd) chk($sformatf("read_%02h", a), avs_readdata, exp_rd);
    chk("irq_out", irq_out, m_irqout);
    got = avs_readdata;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_readdatavalid", avs_readdatavalid, 1'b0);
    chk("rst_irq_out", irq_out, 1'b0);
    chk_ports("rst");
    rst = 1'b0;
  endtask

  logic [31:0] got;

  initial begin
    rst = 1'b1; avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
    solution = '0; status = '0; miner_irq = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Every address reads 0 after reset
    for (int a = 0; a < 32; a++) begin
      step(1, 0, 5'(a), 32'h0, got);
      chk("reset_read_zero", got, 32'h0);
    end

    // Job programming
    step(0, 1, 5'h03, 32'hDEADBEEF, got);
    step(0, 1, 5'h0F, 32'h0000FFFF, got);
    step(0, 1, 5'h10, 32'h00000010, got);
    step(0, 1, 5'h11, 32'h00000001, got);
    step(0, 1, 5'h12, 32'h00000001, got);
    chk("hdr_word3", header[127:96], 32'hDEADBEEF);
    chk("diff_word7", difficulty[255:224], 32'h0000FFFF);
    chk("start_nonce", start_nonce, 64'h1_00000010);
    chk("control", control, 19'h00001);
    chk_ports("job");

    // Write protection while running
    step(0, 1, 5'h00, 32'h12345678, got);
    chk("hdr_protected", header[31:0], 32'h0);
    step(1, 0, 5'h13, 32'h0, got);
    chk("wp_err_set", got[10], 1'b1);
    step(0, 1, 5'h16, 32'h4, got);
    step(1, 0, 5'h13, 32'h0, got);
    chk("wp_err_clr", got[10], 1'b0);

    // Interrupt capture and acknowledge
    step(0, 1, 5'h16, 32'h2, got);
    solution = 64'hAAAA_BBBB_CCCC_DDDD;
    miner_irq = 1'b1;
    step(0, 0, 5'h00, 32'h0, got);
    chk("irq_out_1cyc", irq_out, 1'b0);
    step(0, 0, 5'h00, 32'h0, got);
    chk("irq_out_2cyc", irq_out, 1'b1);
    step(1, 0, 5'h14, 32'h0, got);
    chk("sol_lo", got, 32'hCCCCDDDD);
    step(1, 0, 5'h15, 32'h0, got);
    chk("sol_hi", got, 32'hAAAABBBB);
    step(0, 1, 5'h16, 32'h3, got);
    step(0, 0, 5'h00, 32'h0, got);
    chk("irq_out_acked", irq_out, 1'b0);
    step(0, 1, 5'h12, 32'h0, got);
    miner_irq = 1'b0;
    solution = 64'h1_00000010;
    step(1, 0, 5'h14, 32'h0, got);
    chk("sol_cap_kept", got, 32'hCCCCDDDD);

    // Ack collides with a fresh rise: set wins
    solution = 64'h1111_2222_3333_4444;
    miner_irq = 1'b1;
    step(0, 1, 5'h16, 32'h3, got);
    step(1, 0, 5'h16, 32'h0, got);
    chk("ack_vs_rise", got, 32'h3);
    step(1, 0, 5'h14, 32'h0, got);
    chk("ack_vs_rise_sol", got, 32'h33334444);

    // Run-cycle counter
    miner_irq = 1'b0;
    status = 7'h02;
    step(0, 1, 5'h17, 32'h0, got);
    repeat (100) step(0, 0, 5'h00, 32'h0, got);
    miner_irq = 1'b1;
    repeat (10) step(0, 0, 5'h00, 32'h0, got);
    step(1, 0, 5'h17, 32'h0, got);
    chk("run_cnt_100", got, 32'd100);
    miner_irq = 1'b0;
    repeat (5) step(0, 0, 5'h00, 32'h0, got);
    step(0, 1, 5'h17, 32'hFFFFFFFF, got);
    step(1, 0, 5'h17, 32'h0, got);
    chk("run_cnt_cleared", got, 32'd0);
    step(1, 0, 5'h17, 32'h0, got);
    chk("run_cnt_resume", got, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      status    = 7'($urandom());
      solution  = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) miner_irq = ~miner_irq;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
           $urandom(), got);
    end
    chk_ports("random");

    // Reset in the middle of activity
    status = 7'h02;
    miner_irq = 1'b1;
    do_reset();
    miner_irq = 1'b0;
    status = '0;
    step(1, 0, 5'h13, 32'h0, got);
    step(1, 0, 5'h17, 32'h0, got);
    chk("post_reset_cnt", got, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
